mixcols_col_sched: RTL and testbench
====================================

# mixcols_col_sched

Column-serial sequencer for the AES MixColumns step. It accepts a 128-bit state over a valid/ready handshake and pushes the four columns one per cycle through a single shared column-mix unit. It assembles the mixed state in an output register and presents it downstream over a valid/ready handshake. It sits between ShiftRows and AddRoundKey in the iterative round datapath; the round controller sets `in_bypass` on the final round, where MixColumns is skipped.

## Interface
- No parameters; widths fixed by AES (128-bit state, 32-bit column, 8-bit byte).
- `clk`  in  1  rising-edge clock, sole clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data`/`in_bypass` valid
- `in_ready`  out  1  block can accept; combinational from state and `out_ready`
- `in_data`  in  128  shifted state; byte j = `in_data[127-8j -: 8]`; column c = bytes 4c..4c+3 (byte 4c is row 0)
- `in_bypass`  in  1  1 = pass state through unmixed (final round)
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  128  mixed state, same byte ordering as `in_data`
- `busy`  out  1  high in MIX or DONE

## Operation
- States: IDLE, MIX, DONE. Registers:
  - 2-bit column counter `col`
  - 128-bit input hold register
  - 128-bit output register
- IDLE: `in_ready`=1. When `in_valid`, capture `in_data`.
  - `in_bypass`=0: go to MIX with `col`=0.
  - `in_bypass`=1: load `out_data` directly with the input and go to DONE.
- MIX: each cycle, column `col` of the hold register goes through the shared mixer. Its result is written to the same column of `out_data`, then `col` increments. After `col`=3 is written, go to DONE. `in_ready`=0.
- DONE: `out_valid`=1; `out_data` stays stable until `out_ready`.
  - On `out_ready`, the handshake completes.
  - If `in_valid` is also high in that same cycle, the new block is accepted on that edge, following the IDLE rules. Otherwise return to IDLE.
  - `in_ready` = `out_ready` in DONE.
- Column mix, GF(2^8):
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0); 3·b = xtime(b)^b.
  - r0=2a0^3a1^a2^a3
  - r1=a0^2a1^3a2^a3
  - r2=a0^a1^2a2^3a3
  - r3=3a0^a1^a2^2a3
- Exactly one mixer instance. The counter selects its input column and the output write column.
- No overlap inside MIX: a new block is never accepted while columns are in flight.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - state=IDLE, `col`=0
  - `out_valid`=0, `out_data`=0, `busy`=0
  - `in_ready`=1 once `rst_n` is high
- Mix latency: accept on edge E. Columns 0..3 are written on edges E+1..E+4, and `out_valid` is high in the cycle after E+4.
- Bypass latency: `out_valid` is high in the cycle after the accept edge E.
- Back-to-back throughput:
  - Mixed blocks: one block per 5 cycles when `in_valid`/`out_ready` are held high. The accept and the output handshake coincide on the DONE cycle.
  - Bypass blocks: one block per cycle.
- Backpressure: with `out_ready`=0 in DONE, `out_data` and `out_valid` hold indefinitely, `in_ready`=0, and new input is not accepted.
- Reset mid-MIX or mid-DONE: the block is discarded, with no partial output. `out_valid` drops asynchronously.
- `in_data` only needs to be valid on the accept edge. Changes to it during MIX do not affect the result.
- `out_data` may show partially updated columns during MIX. It is defined only while `out_valid`=1.

## Test plan
- FIPS-197 vector, no bypass:
  - Input `db135345_f20a225c_01010101_c6c6c6c6`.
  - Required: `out_data` = `8e4da1bc_9fdc589d_01010101_c6c6c6c6`.
  - `out_valid` rises exactly 4 edges after the accept.
- Second vector:
  - Input `d4d4d4d5_2d26314c_...` (remaining columns `01010101_c6c6c6c6`).
  - Required: `d5d5d7d6_4d7ebdf8_01010101_c6c6c6c6`.
- Bypass:
  - Input `db135345_f20a225c_01010101_c6c6c6c6` with `in_bypass`=1.
  - Required: output identical to the input, `out_valid` one edge after accept, no mixer cycles.
- Backpressure then back-to-back:
  - Hold `out_ready`=0 for 10 cycles in DONE. Required: `out_data` stable and `in_ready`=0 throughout.
  - Then raise `out_ready` with the next `in_valid` already high. Required: the output handshake and the new accept happen on the same edge, and the second result is correct 4 edges later.
- Reset mid-operation:
  - Assert `rst_n`=0 after column 1 is written. Required: immediate `out_valid`=0, `out_data`=0, `busy`=0.
  - After release, a fresh FIPS vector produces the correct result.
- Streaming:
  - 20 random blocks with random `in_valid`/`out_ready` gaps.
  - Required: every output matches the reference model, in order, with no drops or duplicates.

Source files
------------

// File: rtl/mixcols_col_sched.sv
// Column-serial AES MixColumns sequencer.
// Accepts a 128-bit state, feeds its four columns one per cycle through a
// single shared column mixer, and presents the assembled result downstream.
// The final AES round skips MixColumns, so in_bypass loads the state straight
// into the output register.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | empty, ready for a new block
//   MIX   | one column per cycle through the mixer, col selects column
//   DONE  | result held on out_data until downstream takes it; a new
//         | block may be accepted on the same edge as the handoff
module mixcols_col_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   col;
    logic [127:0] hold_q;
    logic [127:0] out_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         accept;
    logic [31:0]  mix_in;
    logic [31:0]  mix_out;
    logic [7:0]   a0, a1, a2, a3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Ready in IDLE, or in DONE when the held result leaves this cycle.
    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign busy      = busy_q;

    // Column select: the counter picks which held column enters the mixer.
    always_comb begin
        mix_in = hold_q[127:96];
        case (col)
            2'd0:    mix_in = hold_q[127:96];
            2'd1:    mix_in = hold_q[95:64];
            2'd2:    mix_in = hold_q[63:32];
            default: mix_in = hold_q[31:0];
        endcase
    end

    // The single shared column mixer; row 0 sits in the top byte.
    always_comb begin
        a0 = mix_in[31:24];
        a1 = mix_in[23:16];
        a2 = mix_in[15:8];
        a3 = mix_in[7:0];
        mix_out[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        mix_out[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        mix_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        mix_out[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end

    // Sequencer: accept, step columns, hold result until handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= 2'd0;
            hold_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        hold_q <= in_data;
                        busy_q <= 1'b1;
                        if (in_bypass) begin
                            out_q       <= in_data;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            col         <= 2'd0;
                            out_valid_q <= 1'b0;
                            state       <= MIX;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                MIX: begin
                    case (col)
                        2'd0:    out_q[127:96] <= mix_out;
                        2'd1:    out_q[95:64]  <= mix_out;
                        2'd2:    out_q[63:32]  <= mix_out;
                        default: out_q[31:0]   <= mix_out;
                    endcase
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixcols_col_sched.sv
// Self-checking bench for mixcols_col_sched: directed FIPS-197 vectors,
// bypass, backpressure with same-edge handoff, mid-block reset, and a
// randomised stream checked against a scoreboard of reference results.
module tb_mixcols_col_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_bypass = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_rcv = 0;
    bit acc_last = 1'b0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VEC2_IN  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC2_OUT = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    mixcols_col_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Reference MixColumns using the circulant matrix (2 3 1 1).
    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [7:0]   mc [4];
        logic [7:0]   a [4];
        logic [7:0]   r;
        logic [127:0] res;
        mc[0] = 8'h02; mc[1] = 8'h03; mc[2] = 8'h01; mc[3] = 8'h01;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8 * (4 * c + k) -: 8];
            for (int rw = 0; rw < 4; rw++) begin
                r = 8'h00;
                for (int k = 0; k < 4; k++) r = r ^ gmul(a[k], mc[(k - rw + 4) % 4]);
                res[127 - 8 * (4 * c + rw) -: 8] = r;
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: decide handshakes from settled signals, then advance to
    // the next falling edge where the caller drives new inputs.
    task automatic tick();
        #1;
        acc_last = 1'b0;
        if (in_valid && in_ready) begin
            exp_q.push_back(in_bypass ? in_data : ref_mix(in_data));
            n_acc++;
            acc_last = 1'b1;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed=%h expected=none", out_data);
            end else begin
                chk("sb_data", out_data, exp_q.pop_front());
                n_rcv++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send one block, check latency to out_valid, the result, then drain.
    task automatic run_block(input string tag, input logic [127:0] data,
                             input logic byp, input logic [127:0] exp, input int lat);
        in_valid  = 1'b1;
        in_data   = data;
        in_bypass = byp;
        tick();
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        chk1({tag, "_busy"}, busy, 1'b1);
        chk1({tag, "_valid_e0"}, out_valid, lat == 0);
        for (int i = 1; i <= lat; i++) begin
            tick();
            chk1({tag, "_valid_lat"}, out_valid, i == lat);
        end
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1({tag, "_valid_clr"}, out_valid, 1'b0);
        chk1({tag, "_busy_clr"}, busy, 1'b0);
    endtask

    initial begin
        int base_acc;
        int base_rcv;
        int cyc;

        // Reset state
        #1;
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk1("rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Directed vectors and bypass
        run_block("fips", FIPS_IN, 1'b0, FIPS_OUT, 4);
        run_block("vec2", VEC2_IN, 1'b0, VEC2_OUT, 4);
        run_block("bypass", FIPS_IN, 1'b1, FIPS_IN, 0);

        // Backpressure for 10 cycles, then same-edge handoff and accept
        in_valid = 1'b1;
        in_data  = FIPS_IN;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk1("bp_valid", out_valid, 1'b1);
        in_valid = 1'b1;
        in_data  = VEC2_IN;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", out_data, FIPS_OUT);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_valid_hold", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk1("b2b_in_ready", in_ready, 1'b1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk1("b2b_busy", busy, 1'b1);
        chk1("b2b_valid_drop", out_valid, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk1("b2b_valid_lat", out_valid, i == 4);
        end
        chk("b2b_data", out_data, VEC2_OUT);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset after column 1 is written
        in_valid = 1'b1;
        in_data  = FIPS_IN;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk1("midrst_valid", out_valid, 1'b0);
        chk("midrst_data", out_data, '0);
        chk1("midrst_busy", busy, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block("postrst", FIPS_IN, 1'b0, FIPS_OUT, 4);

        // Random stream with gaps on both sides
        base_acc = n_acc;
        base_rcv = n_rcv;
        cyc = 0;
        acc_last = 1'b0;
        while (((n_acc - base_acc) < 20 || exp_q.size() > 0) && cyc < 3000) begin
            if (!in_valid || acc_last) begin
                if ((n_acc - base_acc) < 20 && $urandom_range(0, 2) != 0) begin
                    in_valid  = 1'b1;
                    in_data   = {$urandom, $urandom, $urandom, $urandom};
                    in_bypass = ($urandom_range(0, 3) == 0);
                end else begin
                    in_valid  = 1'b0;
                    in_bypass = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk1("stream_in_time", cyc < 3000, 1'b1);
        chk("stream_count", 128'(n_rcv - base_rcv), 128'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
